// File: rtl/rom_stream_pkg.sv
// rom_stream_pkg: shared state encoding and default widths for the ROM streamer
package rom_stream_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/rom_streamer.sv
// rom_streamer: reads a burst of consecutive words from a combinational ROM onto a valid/ready stream
module rom_streamer
  import rom_stream_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);
  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remaining;
  logic              last_word;
  assign rom_addr  = addr_q;
  assign busy      = (state != IDLE);
  assign last_word = (remaining == (ADDR_W+1)'(1));
  // burst control: the output register refills whenever it is empty or being drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      remaining <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            if (length != '0) begin
              addr_q    <= start_addr;
              remaining <= length;
              state     <= RUN;
            end else done <= 1'b1;
          end
        RUN:
          if (!m_valid || m_ready) begin
            m_data    <= rom_data;
            m_valid   <= 1'b1;
            m_last    <= last_word;
            addr_q    <= addr_q + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
            if (last_word) state <= DRAIN;
          end
        DRAIN:
          if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_streamer.sv
// tb_rom_streamer: directed bursts against a {4'hA, addr} ROM model
module tb_rom_streamer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] start_addr = '0;
  logic [4:0] length = '0;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;
  logic       done;
  int tests = 0;
  int fails = 0;

  rom_streamer #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .rom_addr(rom_addr), .rom_data(rom_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .done(done)
  );

  assign rom_data = {4'hA, rom_addr};
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sa;
    logic [4:0] len;
    int         stall;
    bit         poke;
    logic [7:0] first_d;
    logic [7:0] last_d;
    int         beats;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic [7:0] got[$];
    bit         lst[$];
    int idx = 0, stall_left = v.stall, fv = -1, fx = -1, lx = -1, dn = 0, didx = -1, bz = 0;
    logic [3:0] a;
    @(negedge clk);
    m_ready = 1'b1;
    start = 1'b1;
    start_addr = v.sa;
    length = v.len;
    for (int c = 0; c < v.beats + v.stall + 6; c++) begin
      @(negedge clk);
      idx++;
      if (idx == 1) start = 1'b0;
      if (v.poke && idx == 3) begin
        start = 1'b1;
        start_addr = 4'd10;
        length = 5'd1;
      end
      if (v.poke && idx == 4) start = 1'b0;
      m_ready = 1'b1;
      if (m_valid && stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
        check($sformatf("v%0d stall_hold", n), m_data, v.first_d);
      end
      if (m_valid && fv < 0) fv = idx;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        lst.push_back(m_last);
        if (fx < 0) fx = idx;
        lx = idx;
      end
      if (done) begin
        dn++;
        didx = idx;
      end
      if (busy) bz++;
    end
    check($sformatf("v%0d beat_count", n), got.size(), v.beats);
    check($sformatf("v%0d done_count", n), dn, 1);
    if (v.beats == 0) begin
      check($sformatf("v%0d busy_cycles", n), bz, 0);
      check($sformatf("v%0d valid_seen", n), fv, -1);
      check($sformatf("v%0d done_idx", n), didx, 1);
    end else if (got.size() == v.beats) begin
      check($sformatf("v%0d first_data", n), got[0], v.first_d);
      check($sformatf("v%0d last_data", n), got[v.beats-1], v.last_d);
      check($sformatf("v%0d first_valid_idx", n), fv, 2);
      check($sformatf("v%0d done_idx", n), didx, lx + 1);
      if (v.stall == 0) check($sformatf("v%0d throughput", n), lx - fx, v.beats - 1);
      for (int i = 0; i < v.beats; i++) begin
        a = v.sa + 4'(i);
        check($sformatf("v%0d beat%0d data", n, i), got[i], {4'hA, a});
        check($sformatf("v%0d beat%0d last", n, i), lst[i], (i == v.beats - 1));
      end
    end
  endtask

  initial begin
    vec_t vecs[8];
    vec_t post;
    int dn;
    vecs[0] = '{4'd3,  5'd4,  0, 1'b0, 8'hA3, 8'hA6, 4};
    vecs[1] = '{4'd14, 5'd4,  0, 1'b0, 8'hAE, 8'hA1, 4};
    vecs[2] = '{4'd0,  5'd3,  3, 1'b0, 8'hA0, 8'hA2, 3};
    vecs[3] = '{4'd9,  5'd0,  0, 1'b0, 8'h00, 8'h00, 0};
    vecs[4] = '{4'd15, 5'd16, 0, 1'b0, 8'hAF, 8'hAE, 16};
    vecs[5] = '{4'd7,  5'd1,  0, 1'b0, 8'hA7, 8'hA7, 1};
    vecs[6] = '{4'd2,  5'd5,  0, 1'b1, 8'hA2, 8'hA6, 5};
    vecs[7] = '{4'd12, 5'd6,  2, 1'b0, 8'hAC, 8'hA1, 6};
    #12;
    check("rst m_valid", m_valid, 0);
    check("rst m_data", m_data, 0);
    check("rst m_last", m_last, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst rom_addr", rom_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
    @(negedge clk);
    start = 1'b1;
    start_addr = 4'd0;
    length = 5'd16;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid busy before rst", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid rst m_valid", m_valid, 0);
    check("mid rst m_data", m_data, 0);
    check("mid rst m_last", m_last, 0);
    check("mid rst busy", busy, 0);
    check("mid rst rom_addr", rom_addr, 0);
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("mid rst no_done", dn, 0);
    post = '{4'd5, 5'd2, 0, 1'b0, 8'hA5, 8'hA6, 2};
    run_vec(post, 8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rom_streamer.md
ROM_STREAMER -- requirements
Module: rom_streamer

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the ROM address width and the stream length range (1..2^ADDR_W words).
REQ-002 Parameter DATA_W, default 8, SHALL set the ROM data width and the stream data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 start  input  1  SHALL request a burst; sampled only in IDLE.
REQ-006 start_addr  input  ADDR_W  SHALL give the first ROM address of the burst.
REQ-007 length  input  ADDR_W+1  SHALL give the word count, 0..2^ADDR_W.
REQ-008 rom_addr  output  ADDR_W  SHALL drive the address port of the combinational ROM.
REQ-009 rom_data  input  DATA_W  SHALL be the ROM read data for rom_addr, valid in the same cycle.
REQ-010 m_valid  output  1  SHALL flag valid stream data.
REQ-011 m_ready  input  1  SHALL be downstream acceptance; a beat transfers when m_valid and m_ready are both high on a rising edge.
REQ-012 m_data  output  DATA_W  SHALL carry the registered ROM word.
REQ-013 m_last  output  1  SHALL mark the final beat of a burst.
REQ-014 busy  output  1  SHALL be high in RUN and DRAIN.
REQ-015 done  output  1  SHALL pulse high for exactly one cycle when a burst completes.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DRAIN.
REQ-017 IDLE: start=1 with length>0 SHALL load addr_q<=start_addr and remaining<=length, then go to RUN.
REQ-018 IDLE: start=1 with length=0 SHALL stay in IDLE, emit no beats and pulse done the next cycle.
REQ-019 rom_addr SHALL equal addr_q at all times.
REQ-020 RUN: when m_valid=0 or m_ready=1, the block SHALL load m_data<=rom_data, set m_valid, set m_last<=(remaining==1), increment addr_q, decrement remaining.
REQ-021 RUN: when m_valid=1 and m_ready=0, m_data, m_last, m_valid, addr_q and remaining SHALL hold.
REQ-022 The load that makes remaining 0 SHALL move the FSM from RUN to DRAIN.
REQ-023 DRAIN: on transfer of the m_last beat the block SHALL clear m_valid and m_last, pulse done, and go to IDLE.
REQ-024 m_valid SHALL drop after a transfer when no new word is loaded the same cycle.
REQ-025 First m_valid SHALL rise on the second rising edge after the start cycle; with m_ready held high, throughput SHALL be one word per cycle.
REQ-026 addr_q SHALL wrap from 2^ADDR_W-1 to 0 modulo 2^ADDR_W.
REQ-027 start while busy SHALL be ignored.
REQ-028 m_data SHALL hold stable while m_valid=1 and m_ready=0.

Reset
REQ-029 rst SHALL force state IDLE; addr_q, remaining, m_data, m_valid, m_last, done and busy to 0, regardless of clk.
REQ-030 Reset mid-burst SHALL abort it with no done pulse; the next start after release SHALL run normally.

Structure
REQ-031 The state encoding typedef and the ADDR_W/DATA_W defaults SHALL reside in a shared package (rom_stream_pkg).
REQ-032 The block SHALL be one module with no sub-module; the ROM is instantiated beside it at the next level up.

Verification (bench ROM model: data = {4'hA, addr})
REQ-033 start_addr=3, length=4, m_ready=1 -> beats A3,A4,A5,A6 on consecutive cycles, m_last only on A6, done one cycle after A6 transfers.
REQ-034 start_addr=14, length=4 -> beats AE,AF,A0,A1 (wrap).
REQ-035 start_addr=0, length=3, m_ready low 3 cycles while A0 valid -> m_data holds A0, then A0,A1,A2 in order, no loss or duplication.
REQ-036 length=0 -> no m_valid, done pulses once, busy stays 0.
REQ-037 rst asserted mid-burst of length=16 -> all outputs 0 immediately, no done; a later start_addr=5, length=2 yields A5,A6.
REQ-038 start pulsed during a busy burst -> ignored; output sequence and beat count unchanged.
